// File: rtl/lut_sched.sv
// Shared 4-input LUT evaluator: NREQ requesters, each with its own 16-bit
// truth table, arbitrated round-robin into a single registered response slot.
module lut_sched #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDXW = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_we,
  input  logic [IDXW-1:0]      cfg_idx,
  input  logic [15:0]          cfg_mask,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [4*NREQ-1:0]    req_in,
  output logic [NREQ-1:0]      req_ready,
  output logic                 rsp_valid,
  output logic [IDXW-1:0]      rsp_id,
  output logic                 rsp_out,
  input  logic                 rsp_ready
);

  logic [15:0]     mask_q [NREQ];
  logic [15:0]     mask_d [NREQ];
  logic [IDXW-1:0] ptr_q, ptr_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [IDXW-1:0] rsp_id_q, rsp_id_d;
  logic            rsp_out_q, rsp_out_d;

  logic            accept;
  logic            grant_any;
  logic [IDXW-1:0] grant_idx;
  logic            take;
  logic [15:0]     sel_mask;
  logic [3:0]      sel_opnd;

  assign accept = !rsp_valid_q || rsp_ready;

  // First valid requester scanning upward from ptr, wrapping at NREQ.
  always_comb begin : p_grant
    int unsigned cand;
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = 32'(ptr_q) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      if (!grant_any && req_valid[IDXW'(cand)]) begin
        grant_any = 1'b1;
        grant_idx = IDXW'(cand);
      end
    end
  end

  assign take     = !rst && accept && grant_any;
  assign sel_mask = mask_q[grant_idx];
  assign sel_opnd = req_in[32'(grant_idx)*4 +: 4];

  always_comb begin
    req_ready = '0;
    if (take) req_ready[grant_idx] = 1'b1;
  end

  always_comb begin
    mask_d      = mask_q;
    ptr_d       = ptr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_out_d   = rsp_out_q;
    // Evaluation reads mask_q, so a same-cycle cfg write only affects later grants.
    if (take) begin
      rsp_valid_d = 1'b1;
      rsp_id_d    = grant_idx;
      rsp_out_d   = sel_mask[sel_opnd];
      ptr_d       = (grant_idx == IDXW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
    if (cfg_we && (32'(cfg_idx) < NREQ)) mask_d[cfg_idx] = cfg_mask;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mask_q      <= '{default: '0};
      ptr_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_out_q   <= 1'b0;
    end else begin
      mask_q      <= mask_d;
      ptr_q       <= ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_out_q   <= rsp_out_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_out   = rsp_out_q;

endmodule

// File: tb/tb_lut_sched.sv
// Self-checking bench for lut_sched: directed scenarios plus xorshift-driven
// random traffic, all compared against a behavioural model every cycle.
module tb_lut_sched;
  localparam int NREQ = 4;
  localparam int IDXW = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             cfg_we;
  logic [IDXW-1:0]  cfg_idx;
  logic [15:0]      cfg_mask;
  logic [NREQ-1:0]  req_valid;
  logic [4*NREQ-1:0] req_in;
  logic [NREQ-1:0]  req_ready;
  logic             rsp_valid;
  logic [IDXW-1:0]  rsp_id;
  logic             rsp_out;
  logic             rsp_ready;

  int total = 0;
  int bad   = 0;

  logic [15:0] m_mask [NREQ];
  int          m_ptr;
  bit          m_valid;
  int          m_id;
  bit          m_out;
  logic [63:0] xs;

  lut_sched #(.NREQ(NREQ), .IDXW(IDXW)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_mask(cfg_mask),
    .req_valid(req_valid), .req_in(req_in), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_out(rsp_out), .rsp_ready(rsp_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [NREQ-1:0] exp_ready();
    logic [NREQ-1:0] r;
    r = '0;
    if (rst || (m_valid && !rsp_ready)) return r;
    for (int k = 0; k < NREQ; k++) begin
      int i;
      i = (m_ptr + k) % NREQ;
      if (req_valid[i]) begin
        r[i] = 1'b1;
        return r;
      end
    end
    return r;
  endfunction

  task automatic compare();
    chk("req_ready", 32'(req_ready), 32'(exp_ready()));
    chk("rsp_valid", 32'(rsp_valid), 32'(m_valid));
    if (m_valid) begin
      chk("rsp_id", 32'(rsp_id), m_id);
      chk("rsp_out", 32'(rsp_out), 32'(m_out));
    end
  endtask

  task automatic model_update();
    logic [NREQ-1:0] r;
    logic [3:0]      op;
    logic [15:0]     mm;
    int              g;
    r = exp_ready();
    g = -1;
    for (int i = 0; i < NREQ; i++) if (r[i]) g = i;
    if (rst) begin
      for (int i = 0; i < NREQ; i++) m_mask[i] = 16'h0000;
      m_ptr = 0; m_valid = 0; m_id = 0; m_out = 0;
    end else begin
      if (g >= 0) begin
        op      = req_in[4*g +: 4];
        mm      = m_mask[g];
        m_out   = mm[op];
        m_valid = 1;
        m_id    = g;
        m_ptr   = (g + 1) % NREQ;
      end else if (rsp_ready) begin
        m_valid = 0;
      end
      if (cfg_we && int'(cfg_idx) < NREQ) m_mask[cfg_idx] = cfg_mask;
    end
  endtask

  task automatic step();
    #1;
    compare();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    rst = 0; cfg_we = 0; cfg_idx = '0; cfg_mask = '0;
    req_valid = '0; req_in = '0; rsp_ready = 1;
  endtask

  task automatic do_reset();
    quiet();
    rst = 1;
    step();
    rst = 0;
  endtask

  function automatic logic ref_fn(input logic [3:0] x);
    return ((x[0] & ~x[1]) ^ x[2]) | x[3];
  endfunction

  initial begin
    for (int i = 0; i < NREQ; i++) m_mask[i] = 16'h0000;
    m_ptr = 0; m_valid = 0; m_id = 0; m_out = 0;

    // Reset with requests and a cfg write pending: both must be ignored.
    quiet();
    rst = 1; req_valid = '1; cfg_we = 1; cfg_idx = 0; cfg_mask = 16'hFFFF;
    @(posedge clk); #1;
    chk("rst_valid", 32'(rsp_valid), 0);
    chk("rst_id", 32'(rsp_id), 0);
    chk("rst_out", 32'(rsp_out), 0);
    chk("rst_ready", 32'(req_ready), 0);
    step();
    quiet();

    // Truth-table sweep on requester 0.
    cfg_we = 1; cfg_idx = 0; cfg_mask = 16'hFFD2;
    step();
    cfg_we = 0;
    for (int x = 0; x < 16; x++) begin
      req_valid = 4'b0001; req_in = 16'(x);
      step();
      chk("sweep_valid", 32'(rsp_valid), 1);
      chk("sweep_id", 32'(rsp_id), 0);
      chk("sweep_out", 32'(rsp_out), 32'(ref_fn(4'(x))));
    end

    // Full-load round robin.
    do_reset();
    req_valid = '1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("rr_valid", 32'(rsp_valid), 1);
      chk("rr_id", 32'(rsp_id), i % NREQ);
    end

    // Backpressure hold, then resume after the held id.
    do_reset();
    req_valid = 4'b0010;
    step();
    chk("bp_first_id", 32'(rsp_id), 1);
    req_valid = '1; rsp_ready = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_valid", 32'(rsp_valid), 1);
      chk("bp_id", 32'(rsp_id), 1);
      chk("bp_ready", 32'(req_ready), 0);
    end
    rsp_ready = 1;
    #1 chk("bp_release_ready", 32'(req_ready), 32'(4'b0100));
    step();
    chk("bp_release_id", 32'(rsp_id), 2);

    // Same-cycle cfg write and evaluation of index 2.
    do_reset();
    req_valid = 4'b0100; cfg_we = 1; cfg_idx = 2; cfg_mask = 16'hFFFF;
    step();
    chk("wr_old_id", 32'(rsp_id), 2);
    chk("wr_old_out", 32'(rsp_out), 0);
    cfg_we = 0;
    step();
    chk("wr_new_out", 32'(rsp_out), 1);

    // Mid-stream reset discards response and masks.
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      cfg_we = 1; cfg_idx = IDXW'(i); cfg_mask = 16'hFFFF;
      step();
    end
    cfg_we = 0; req_valid = 4'b1000;
    step();
    chk("mr_pre_out", 32'(rsp_out), 1);
    rst = 1; req_valid = '1; rsp_ready = 0;
    #1 chk("mr_rst_ready", 32'(req_ready), 0);
    step();
    chk("mr_valid", 32'(rsp_valid), 0);
    rst = 0; rsp_ready = 1;
    #1 chk("mr_first_ready", 32'(req_ready), 32'(4'b0001));
    step();
    chk("mr_first_id", 32'(rsp_id), 0);
    chk("mr_first_out", 32'(rsp_out), 0);

    // Randomised traffic.
    xs = {32'($urandom), 32'($urandom)} | 64'h1;
    for (int n = 0; n < 10000; n++) begin
      xs = xs ^ (xs << 13);
      xs = xs ^ (xs >> 7);
      xs = xs ^ (xs << 17);
      rst       = (xs[7:0] == 8'h00);
      cfg_we    = (xs[10:8] == 3'b000);
      cfg_idx   = xs[12:11];
      cfg_mask  = xs[28:13];
      req_valid = xs[32:29];
      req_in    = xs[48:33];
      rsp_ready = (xs[50:49] != 2'b00);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/lut_sched.md
LUT_SCHED -- requirements
Module: lut_sched

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters sharing the LUT, legal range 2..8.
REQ-002 SHALL have parameter IDXW, default 2, requester index width, equal to ceil(log2(NREQ)).
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port cfg_we, input, 1, truth-table write strobe.
REQ-006 SHALL have port cfg_idx, input, IDXW, index of the requester whose truth table is written.
REQ-007 SHALL have port cfg_mask, input, 16, truth-table value to write.
REQ-008 SHALL have port req_valid, input, NREQ, one evaluation request per requester.
REQ-009 SHALL have port req_in, input, 4*NREQ, operands; requester i uses bits [4i+3:4i], ordered {d,c,b,a} with a as LSB.
REQ-010 SHALL have port req_ready, output, NREQ, per-requester accept.
REQ-011 SHALL have port rsp_valid, output, 1, response available.
REQ-012 SHALL have port rsp_id, output, IDXW, requester that owns the response.
REQ-013 SHALL have port rsp_out, output, 1, LUT result.
REQ-014 SHALL have port rsp_ready, input, 1, response consumer accept.

Function
REQ-015 SHALL hold NREQ 16-bit truth tables; each evaluation result SHALL be mask[i][{d,c,b,a}].
REQ-016 On cfg_we=1, mask[cfg_idx] SHALL take cfg_mask at the clock edge; cfg_idx >= NREQ SHALL be ignored.
REQ-017 Accept condition: accept = !rsp_valid || rsp_ready.
REQ-018 When accept=1 and any req_valid is set, exactly one requester SHALL be granted, chosen round-robin starting at pointer ptr.
REQ-019 req_ready SHALL be one-hot on the granted bit and all-zero otherwise; a transfer occurs when req_valid[i] && req_ready[i].
REQ-020 After a grant to requester g, ptr SHALL become (g+1) mod NREQ; with no grant, ptr SHALL hold.
REQ-021 Latency: a transfer at edge N SHALL yield rsp_valid=1, rsp_id=g and rsp_out at edge N (registered output, visible in cycle N+1).
REQ-022 While rsp_valid=1 and rsp_ready=0, rsp_valid, rsp_id and rsp_out SHALL hold stable and req_ready SHALL be all-zero.
REQ-023 When rsp_valid=1 and rsp_ready=1 with no new grant, rsp_valid SHALL clear at the next edge.
REQ-024 Throughput with rsp_ready held at 1 SHALL be one evaluation per cycle.
REQ-025 A cfg write and an evaluation of the same index in the same cycle: the evaluation SHALL use the old mask; the new mask SHALL apply from the next cycle.
REQ-026 Requester operands SHALL be sampled only in the transfer cycle; requesters hold req_in stable while req_valid=1 and req_ready=0.
REQ-027 A single requester continuously valid SHALL be granted every accept cycle; starvation of any valid requester SHALL NOT exceed NREQ-1 grants.

Reset
REQ-028 On rst=1 at an edge: rsp_valid=0, rsp_id=0, rsp_out=0, ptr=0, all masks=16'h0000.
REQ-029 During rst=1, req_ready SHALL be all-zero and cfg_we SHALL be ignored.
REQ-030 Reset mid-stream SHALL discard any pending response without a handshake.

Verification
REQ-031 Write 16'hFFD2 to idx 0, sweep all 16 operands on requester 0 with rsp_ready=1 -> rsp_out equals ((a&~b)^c)|d each cycle, rsp_id=0, one-cycle latency.
REQ-032 All four req_valid held at 1, rsp_ready=1, from reset -> rsp_id sequence 0,1,2,3,0,1... with no idle cycles.
REQ-033 rsp_ready=0 for 5 cycles while rsp_valid=1 -> rsp_* stable and req_ready=0; on release the next grant is the requester after the held rsp_id.
REQ-034 idx 2 mask 16'h0000, cfg_we writing 16'hFFFF to idx 2 in the cycle requester 2 is granted -> response 0; the next requester-2 response is 1.
REQ-035 rst pulsed while rsp_valid=1 and masks loaded -> next cycle rsp_valid=0; any evaluation returns 0 until masks are rewritten; first grant goes to requester 0.
REQ-036 10,000 xorshift64-randomised cycles of cfg writes, req_valid, operands and rsp_ready -> every response matches a reference model; no mismatch asserted.
